rotation_amount_finder: RTL and testbench

- Sequential inverse of the team's N-bit rotate-left/right barrel shifter. Given an original word a and a rotated word y, the block recovers the rotation amount and direction (amt, lr).
- Direction convention matches the shifter: lr=0 means y = rotate-right(a, amt); lr=1 means y = rotate-left(a, amt).
- Iterative search, one candidate rotation per clock, with a start/busy/done handshake.
- Used for self-check and loopback of the shifter datapath on the FPGA board.

---
 rtl/rot_pkg.sv | 13 +
 rtl/rotation_amount_finder.sv | 111 +++++++++++
 tb/tb_rotation_amount_finder.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/rot_pkg.sv
// Shared rotate helpers and FSM state type for the barrel shifter and its inverse search.
package rot_pkg;

  localparam int ROT_N = 3;
  localparam int ROT_W = 1 << ROT_N;

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} rot_state_t;

  function automatic logic [ROT_W-1:0] rotr1(input logic [ROT_W-1:0] v);
    return {v[0], v[ROT_W-1:1]};
  endfunction

endpackage

// File: rtl/rotation_amount_finder.sv
// Recovers (amt, lr) such that y is a rotation of a, testing one right-rotation per clock.
module rotation_amount_finder
  import rot_pkg::*;
#(
  parameter int N = ROT_N
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [(1<<N)-1:0] a,
  input  logic [(1<<N)-1:0] y,
  output logic         busy,
  output logic         done,
  output logic         found,
  output logic [N-1:0] amt,
  output logic         lr
);

  localparam int W = 1 << N;
  localparam logic [N:0] LAST_CNT = (N+1)'(W - 1);
  localparam logic [N:0] HALF_CNT = (N+1)'(W / 2);
  localparam logic [N:0] FULL_CNT = (N+1)'(W);

  rot_state_t r_state;
  rot_state_t w_state_next;
  logic [W-1:0] r_cand;
  logic [W-1:0] r_tgt;
  logic [N:0]   r_cnt;
  logic         r_found;
  logic [N-1:0] r_amt;
  logic         r_lr;

  logic [W-1:0] w_cand_rot;
  logic         w_match;
  logic         w_last;
  logic [N:0]   w_left_amt;

  generate
    if (W == ROT_W) begin : g_pkg_rot
      assign w_cand_rot = rotr1(r_cand);
    end else begin : g_local_rot
      assign w_cand_rot = {r_cand[0], r_cand[W-1:1]};
    end
  endgenerate

  assign w_match    = (r_cand == r_tgt);
  assign w_last     = (r_cnt == LAST_CNT);
  // Left amount wraps modulo 2**N; only reachable for cnt > W/2 so it never wraps in practice.
  assign w_left_amt = FULL_CNT - r_cnt;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = SEARCH;
      SEARCH:  if (w_match || w_last) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cand  <= '0;
      r_tgt   <= '0;
      r_cnt   <= '0;
      r_found <= 1'b0;
      r_amt   <= '0;
      r_lr    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_cand <= a;
            r_tgt  <= y;
            r_cnt  <= '0;
          end
        end
        SEARCH: begin
          if (w_match) begin
            r_found <= 1'b1;
            // A tie at exactly half a word is reported as a right rotation.
            if (r_cnt <= HALF_CNT) begin
              r_amt <= r_cnt[N-1:0];
              r_lr  <= 1'b0;
            end else begin
              r_amt <= w_left_amt[N-1:0];
              r_lr  <= 1'b1;
            end
          end else if (w_last) begin
            r_found <= 1'b0;
            r_amt   <= '0;
            r_lr    <= 1'b0;
          end else begin
            r_cnt  <= r_cnt + 1'b1;
            r_cand <= w_cand_rot;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy  = (r_state == SEARCH);
  assign done  = (r_state == DONE);
  assign found = r_found;
  assign amt   = r_amt;
  assign lr    = r_lr;

endmodule

// File: tb/tb_rotation_amount_finder.sv
// Directed bench for rotation_amount_finder with a cycle-level reference model and per-cycle compare.
module tb_rotation_amount_finder;

  localparam int N = 3;
  localparam int W = 1 << N;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] y = '0;
  logic         busy, done, found, lr;
  logic [N-1:0] amt;

  int n_cmp = 0;
  int n_err = 0;

  rotation_amount_finder #(.N(N)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .y(y),
    .busy(busy), .done(done), .found(found), .amt(amt), .lr(lr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] rot_right(input logic [W-1:0] v, input int k);
    logic [2*W-1:0] dbl;
    dbl = {v, v} >> k;
    return dbl[W-1:0];
  endfunction

  // Reference: first matching right-rotation count, folded into amount and direction.
  task automatic model_solve(input logic [W-1:0] va, input logic [W-1:0] vy,
                             output bit f, output int am, output bit l, output int lat);
    int k;
    k = -1;
    for (int i = 0; i < W; i++)
      if (k < 0 && rot_right(va, i) == vy) k = i;
    if (k < 0) begin
      f = 0; am = 0; l = 0; lat = W;
    end else begin
      f = 1; lat = k + 1;
      if (k <= W / 2) begin am = k; l = 0; end
      else begin am = (W - k) % W; l = 1; end
    end
  endtask

  bit m_active, m_busy, m_done, m_found, m_lr, p_found, p_lr, prev_done;
  int m_amt, p_amt, m_lat, m_e;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_active = 0; m_busy = 0; m_done = 0;
      m_found = 0; m_amt = 0; m_lr = 0; m_e = 0; m_lat = 0;
    end else begin
      prev_done = m_done;
      m_done = 0;
      if (m_active) begin
        m_e++;
        if (m_e == m_lat) begin
          m_active = 0; m_busy = 0; m_done = 1;
          m_found = p_found; m_amt = p_amt; m_lr = p_lr;
        end
      end else if (!prev_done && start) begin
        model_solve(a, y, p_found, p_amt, p_lr, m_lat);
        m_e = 0; m_active = 1; m_busy = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("busy", int'(busy), int'(m_busy));
      chk("done", int'(done), int'(m_done));
      chk("busy_done_excl", int'(busy & done), 0);
      chk("found", int'(found), int'(m_found));
      chk("amt", int'(amt), m_amt);
      chk("lr", int'(lr), int'(m_lr));
    end
  end

  task automatic run_vec(input logic [W-1:0] va, input logic [W-1:0] vy, input bit hold,
                         input int e_found, input int e_amt, input int e_lr, input int e_edge);
    int e;
    bit ok;
    bit mf, ml;
    int ma, mlat;
    model_solve(va, vy, mf, ma, ml, mlat);
    chk("model_amt_pin", ma, e_amt);
    chk("model_lat_pin", mlat, e_edge);
    @(negedge clk);
    a = va; y = vy; start = 1'b1;
    @(posedge clk);
    e = 0; ok = 0;
    while (e < 20) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      a = ~va; y = ~vy;
      if (done) begin ok = 1; break; end
      @(posedge clk);
      e++;
    end
    start = 1'b0;
    chk("done_seen", int'(ok), 1);
    chk("done_edge", e, e_edge);
    chk("lit_found", int'(found), e_found);
    chk("lit_amt", int'(amt), e_amt);
    chk("lit_lr", int'(lr), e_lr);
    $display("vec a=%02h y=%02h hold=%0d -> found=%0d amt=%0d lr=%0d done after edge %0d",
             va, vy, hold, found, amt, lr, e);
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_found", int'(found), 0);
    chk("rst_amt", int'(amt), 0);
    reset = 1'b0;
    @(negedge clk);

    run_vec(8'hB4, 8'h96, 0, 1, 3, 0, 4);
    run_vec(8'hB4, 8'hD2, 0, 1, 2, 1, 7);
    run_vec(8'h5A, 8'h5A, 0, 1, 0, 0, 1);
    run_vec(8'h0F, 8'hF0, 0, 1, 4, 0, 5);
    run_vec(8'hB4, 8'hB5, 1, 0, 0, 0, 8);
    run_vec(8'hAA, 8'h55, 0, 1, 1, 0, 2);

    // Abort a k=6 search with reset shortly after edge 3.
    @(negedge clk);
    a = 8'hB4; y = 8'hD2; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_found", int'(found), 0);
    chk("abort_amt", int'(amt), 0);
    chk("abort_lr", int'(lr), 0);
    $display("reset asserted mid-search: busy=%0d done=%0d found=%0d amt=%0d lr=%0d",
             busy, done, found, amt, lr);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_vec(8'h01, 8'h80, 0, 1, 1, 0, 2);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, got running, expected finished");
    $fatal(1);
  end

endmodule
